// File: rtl/ld_st_buffer_if.sv
// Bundle of the address-unit allocate port, CDB snoop, ROB commit/flush and memory-unit issue
// port of the load/store buffer.
interface ld_st_buffer_if #(
    parameter int unsigned ROB_SIZE_BITS = 4,
    parameter int unsigned MEMORY_BITS   = 11
);
    logic                     AU_LdStB_VALID_Inst;
    logic [ROB_SIZE_BITS:0]   AU_LdStB_ROBEN;
    logic [4:0]               AU_LdStB_Rd;
    logic [11:0]              AU_LdStB_opcode;
    logic [ROB_SIZE_BITS:0]   AU_LdStB_ROBEN1;
    logic [ROB_SIZE_BITS:0]   AU_LdStB_ROBEN2;
    logic [31:0]              AU_LdStB_ROBEN1_VAL;
    logic [31:0]              AU_LdStB_ROBEN2_VAL;
    logic [31:0]              AU_LdStB_Immediate;
    logic                     CDB_VALID;
    logic [ROB_SIZE_BITS:0]   CDB_ROBEN;
    logic [31:0]              CDB_Write_Data;
    logic                     ROB_Commit_VALID;
    logic [ROB_SIZE_BITS:0]   ROB_Commit_ROBEN;
    logic                     ROB_FLUSH;
    logic                     LdStB_FULL;
    logic                     LdStB_EMPTY;
    logic                     LdStB_MEMU_VALID;
    logic [ROB_SIZE_BITS:0]   LdStB_MEMU_ROBEN;
    logic [4:0]               LdStB_MEMU_Rd;
    logic [11:0]              LdStB_MEMU_opcode;
    logic [MEMORY_BITS-1:0]   LdStB_MEMU_Address;
    logic [31:0]              LdStB_MEMU_WriteData;

    modport master (
        output AU_LdStB_VALID_Inst, AU_LdStB_ROBEN, AU_LdStB_Rd, AU_LdStB_opcode,
               AU_LdStB_ROBEN1, AU_LdStB_ROBEN2, AU_LdStB_ROBEN1_VAL, AU_LdStB_ROBEN2_VAL,
               AU_LdStB_Immediate, CDB_VALID, CDB_ROBEN, CDB_Write_Data,
               ROB_Commit_VALID, ROB_Commit_ROBEN, ROB_FLUSH,
        input  LdStB_FULL, LdStB_EMPTY, LdStB_MEMU_VALID, LdStB_MEMU_ROBEN, LdStB_MEMU_Rd,
               LdStB_MEMU_opcode, LdStB_MEMU_Address, LdStB_MEMU_WriteData
    );

    modport slave (
        input  AU_LdStB_VALID_Inst, AU_LdStB_ROBEN, AU_LdStB_Rd, AU_LdStB_opcode,
               AU_LdStB_ROBEN1, AU_LdStB_ROBEN2, AU_LdStB_ROBEN1_VAL, AU_LdStB_ROBEN2_VAL,
               AU_LdStB_Immediate, CDB_VALID, CDB_ROBEN, CDB_Write_Data,
               ROB_Commit_VALID, ROB_Commit_ROBEN, ROB_FLUSH,
        output LdStB_FULL, LdStB_EMPTY, LdStB_MEMU_VALID, LdStB_MEMU_ROBEN, LdStB_MEMU_Rd,
               LdStB_MEMU_opcode, LdStB_MEMU_Address, LdStB_MEMU_WriteData
    );
endinterface

// File: rtl/ld_st_buffer.sv
// Circular in-order load/store buffer: holds operand tags, wakes them from the CDB and issues
// the head entry to the memory unit (stores additionally wait for their ROB commit).
module ld_st_buffer #(
    parameter int unsigned BUFFER_SIZE_BITS = 4,
    parameter int unsigned ROB_SIZE_BITS    = 4,
    parameter int unsigned MEMORY_BITS      = 11
) (
    input logic           clk,
    input logic           rst,
    ld_st_buffer_if.slave bus
);
    localparam int          Depth = 1 << BUFFER_SIZE_BITS;
    localparam logic [11:0] OpLw  = 12'h8C0;
    localparam logic [11:0] OpSw  = 12'hAC0;

    typedef logic [ROB_SIZE_BITS:0]      tag_t;
    typedef logic [BUFFER_SIZE_BITS-1:0] ptr_t;
    typedef logic [BUFFER_SIZE_BITS:0]   cnt_t;

    ptr_t             head_q, head_d, tail_q, tail_d;
    cnt_t             count_q, count_d;
    logic [Depth-1:0] busy_q, busy_d;

    logic        is_sw_a [Depth];
    tag_t        roben_a [Depth];
    logic [4:0]  rd_a    [Depth];
    tag_t        q1_a    [Depth];
    tag_t        q2_a    [Depth];
    logic [31:0] v1_a    [Depth];
    logic [31:0] v2_a    [Depth];
    logic [31:0] imm_a   [Depth];

    logic                   memu_valid_q;
    tag_t                   memu_roben_q;
    logic [4:0]             memu_rd_q;
    logic [11:0]            memu_opcode_q;
    logic [MEMORY_BITS-1:0] memu_address_q;
    logic [31:0]            memu_wdata_q;

    logic                   full, empty, op_ok, alloc, cdb_live, fwd1, fwd2;
    logic                   head_ready, issue;
    logic [MEMORY_BITS-1:0] ea;

    always_comb begin
        full     = (count_q == cnt_t'(Depth));
        empty    = (count_q == '0);
        op_ok    = (bus.AU_LdStB_opcode == OpLw) || (bus.AU_LdStB_opcode == OpSw);
        alloc    = bus.AU_LdStB_VALID_Inst && !full && op_ok && !bus.ROB_FLUSH;
        // Tag 0 means "value present", so a zero CDB tag can never wake anything.
        cdb_live = bus.CDB_VALID && (bus.CDB_ROBEN != '0);
        fwd1     = cdb_live && (bus.AU_LdStB_ROBEN1 == bus.CDB_ROBEN);
        fwd2     = cdb_live && (bus.AU_LdStB_ROBEN2 == bus.CDB_ROBEN);
        head_ready = busy_q[head_q] && (q1_a[head_q] == '0) &&
                     (!is_sw_a[head_q] ||
                      ((q2_a[head_q] == '0) && bus.ROB_Commit_VALID &&
                       (bus.ROB_Commit_ROBEN == roben_a[head_q])));
        issue    = head_ready && !bus.ROB_FLUSH;
        ea       = MEMORY_BITS'(v1_a[head_q] + imm_a[head_q]);
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        busy_d  = busy_q;
        if (bus.ROB_FLUSH) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            busy_d  = '0;
        end else begin
            if (issue) begin
                busy_d[head_q] = 1'b0;
                head_d         = head_q + ptr_t'(1);
            end
            if (alloc) begin
                busy_d[tail_q] = 1'b1;
                tail_d         = tail_q + ptr_t'(1);
            end
            if (alloc && !issue) begin
                count_d = count_q + cnt_t'(1);
            end else if (issue && !alloc) begin
                count_d = count_q - cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            busy_q         <= '0;
            memu_valid_q   <= 1'b0;
            memu_roben_q   <= '0;
            memu_rd_q      <= '0;
            memu_opcode_q  <= '0;
            memu_address_q <= '0;
            memu_wdata_q   <= '0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            busy_q       <= busy_d;
            memu_valid_q <= issue;
            if (issue) begin
                memu_roben_q   <= roben_a[head_q];
                memu_rd_q      <= rd_a[head_q];
                memu_opcode_q  <= is_sw_a[head_q] ? OpSw : OpLw;
                memu_address_q <= ea;
                memu_wdata_q   <= is_sw_a[head_q] ? v2_a[head_q] : '0;
            end
        end
    end

    // Payload storage needs no reset: busy bits alone qualify an entry.
    for (genvar g = 0; g < Depth; g++) begin : gen_entry
        logic        is_sw_q;
        tag_t        roben_q, q1_q, q2_q;
        logic [4:0]  rd_q;
        logic [31:0] v1_q, v2_q, imm_q;
        logic        wr;

        assign wr = alloc && (tail_q == ptr_t'(g));

        always_ff @(posedge clk) begin
            if (wr) begin
                is_sw_q <= (bus.AU_LdStB_opcode == OpSw);
                roben_q <= bus.AU_LdStB_ROBEN;
                rd_q    <= bus.AU_LdStB_Rd;
                imm_q   <= bus.AU_LdStB_Immediate;
                q1_q    <= fwd1 ? '0 : bus.AU_LdStB_ROBEN1;
                v1_q    <= fwd1 ? bus.CDB_Write_Data : bus.AU_LdStB_ROBEN1_VAL;
                q2_q    <= fwd2 ? '0 : bus.AU_LdStB_ROBEN2;
                v2_q    <= fwd2 ? bus.CDB_Write_Data : bus.AU_LdStB_ROBEN2_VAL;
            end else if (busy_q[g] && cdb_live) begin
                if (q1_q == bus.CDB_ROBEN) begin
                    q1_q <= '0;
                    v1_q <= bus.CDB_Write_Data;
                end
                if (q2_q == bus.CDB_ROBEN) begin
                    q2_q <= '0;
                    v2_q <= bus.CDB_Write_Data;
                end
            end
        end

        assign is_sw_a[g] = is_sw_q;
        assign roben_a[g] = roben_q;
        assign rd_a[g]    = rd_q;
        assign q1_a[g]    = q1_q;
        assign q2_a[g]    = q2_q;
        assign v1_a[g]    = v1_q;
        assign v2_a[g]    = v2_q;
        assign imm_a[g]   = imm_q;
    end

    assign bus.LdStB_FULL           = full;
    assign bus.LdStB_EMPTY          = empty;
    assign bus.LdStB_MEMU_VALID     = memu_valid_q;
    assign bus.LdStB_MEMU_ROBEN     = memu_roben_q;
    assign bus.LdStB_MEMU_Rd        = memu_rd_q;
    assign bus.LdStB_MEMU_opcode    = memu_opcode_q;
    assign bus.LdStB_MEMU_Address   = memu_address_q;
    assign bus.LdStB_MEMU_WriteData = memu_wdata_q;
endmodule

// File: tb/tb_ld_st_buffer.sv
// Bench for ld_st_buffer: directed scenarios plus random traffic checked against a
// queue-based reference model of the buffer.
module tb_ld_st_buffer;
    localparam logic [11:0] LW = 12'h8C0;
    localparam logic [11:0] SW = 12'hAC0;

    typedef struct {
        bit          is_sw;
        logic [4:0]  roben;
        logic [4:0]  rd;
        logic [4:0]  q1;
        logic [31:0] v1;
        logic [4:0]  q2;
        logic [31:0] v2;
        logic [31:0] imm;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    ent_t        mq[$];
    bit          e_valid;
    logic [4:0]  e_roben, e_rd;
    logic [11:0] e_op;
    logic [10:0] e_addr;
    logic [31:0] e_wdata;

    ld_st_buffer_if bus ();

    ld_st_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic set_idle();
        bus.AU_LdStB_VALID_Inst = 1'b0;
        bus.AU_LdStB_ROBEN      = '0;
        bus.AU_LdStB_Rd         = '0;
        bus.AU_LdStB_opcode     = '0;
        bus.AU_LdStB_ROBEN1     = '0;
        bus.AU_LdStB_ROBEN2     = '0;
        bus.AU_LdStB_ROBEN1_VAL = '0;
        bus.AU_LdStB_ROBEN2_VAL = '0;
        bus.AU_LdStB_Immediate  = '0;
        bus.CDB_VALID           = 1'b0;
        bus.CDB_ROBEN           = '0;
        bus.CDB_Write_Data      = '0;
        bus.ROB_Commit_VALID    = 1'b0;
        bus.ROB_Commit_ROBEN    = '0;
        bus.ROB_FLUSH           = 1'b0;
    endtask

    task automatic alloc_in(input logic [11:0] op, input logic [4:0] roben, input logic [4:0] rd,
                            input logic [4:0] r1, input logic [4:0] r2, input logic [31:0] v1,
                            input logic [31:0] v2, input logic [31:0] imm);
        bus.AU_LdStB_VALID_Inst = 1'b1;
        bus.AU_LdStB_opcode     = op;
        bus.AU_LdStB_ROBEN      = roben;
        bus.AU_LdStB_Rd         = rd;
        bus.AU_LdStB_ROBEN1     = r1;
        bus.AU_LdStB_ROBEN2     = r2;
        bus.AU_LdStB_ROBEN1_VAL = v1;
        bus.AU_LdStB_ROBEN2_VAL = v2;
        bus.AU_LdStB_Immediate  = imm;
    endtask

    task automatic cdb_in(input logic [4:0] tag, input logic [31:0] data);
        bus.CDB_VALID      = 1'b1;
        bus.CDB_ROBEN      = tag;
        bus.CDB_Write_Data = data;
    endtask

    // Reference behaviour for one clock edge, using the inputs present at that edge.
    function automatic void model_step();
        ent_t        e;
        bit          was_full;
        bit          live;
        logic [31:0] sum;
        was_full = (mq.size() == 16);
        live     = bus.CDB_VALID && (bus.CDB_ROBEN != 0);
        e_valid  = 1'b0;
        if (!bus.ROB_FLUSH && mq.size() > 0) begin
            e = mq[0];
            if (e.q1 == 0 && (!e.is_sw || (e.q2 == 0 && bus.ROB_Commit_VALID &&
                                           bus.ROB_Commit_ROBEN == e.roben))) begin
                sum     = e.v1 + e.imm;
                e_valid = 1'b1;
                e_roben = e.roben;
                e_rd    = e.rd;
                e_op    = e.is_sw ? SW : LW;
                e_addr  = sum[10:0];
                e_wdata = e.is_sw ? e.v2 : 32'd0;
                void'(mq.pop_front());
            end
        end
        if (bus.ROB_FLUSH) begin
            mq.delete();
        end else begin
            for (int i = 0; i < mq.size(); i++) begin
                e = mq[i];
                if (live && e.q1 == bus.CDB_ROBEN) begin e.q1 = 0; e.v1 = bus.CDB_Write_Data; end
                if (live && e.q2 == bus.CDB_ROBEN) begin e.q2 = 0; e.v2 = bus.CDB_Write_Data; end
                mq[i] = e;
            end
            if (bus.AU_LdStB_VALID_Inst && !was_full &&
                (bus.AU_LdStB_opcode == LW || bus.AU_LdStB_opcode == SW)) begin
                e.is_sw = (bus.AU_LdStB_opcode == SW);
                e.roben = bus.AU_LdStB_ROBEN;
                e.rd    = bus.AU_LdStB_Rd;
                e.imm   = bus.AU_LdStB_Immediate;
                e.q1    = bus.AU_LdStB_ROBEN1;
                e.v1    = bus.AU_LdStB_ROBEN1_VAL;
                e.q2    = bus.AU_LdStB_ROBEN2;
                e.v2    = bus.AU_LdStB_ROBEN2_VAL;
                if (live && e.q1 == bus.CDB_ROBEN) begin e.q1 = 0; e.v1 = bus.CDB_Write_Data; end
                if (live && e.q2 == bus.CDB_ROBEN) begin e.q2 = 0; e.v2 = bus.CDB_Write_Data; end
                mq.push_back(e);
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        set_idle();
    endtask

    task automatic test_reset();
        set_idle();
        #3 rst = 1'b0;
        #1;
        mq.delete();
        e_valid = 0; e_roben = 0; e_rd = 0; e_op = 0; e_addr = 0; e_wdata = 0;
        vectors++;
        if (bus.LdStB_MEMU_VALID !== 1'b0 || bus.LdStB_EMPTY !== 1'b1 || bus.LdStB_FULL !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: valid=%b empty=%b full=%b, required 0/1/0",
                     bus.LdStB_MEMU_VALID, bus.LdStB_EMPTY, bus.LdStB_FULL);
        end
        vectors++;
        if ({bus.LdStB_MEMU_ROBEN, bus.LdStB_MEMU_Rd, bus.LdStB_MEMU_opcode,
             bus.LdStB_MEMU_Address, bus.LdStB_MEMU_WriteData} !== '0) begin
            miscompares++;
            $display("FAIL reset_payload: roben=%h rd=%h op=%h addr=%h wdata=%h, required all 0",
                     bus.LdStB_MEMU_ROBEN, bus.LdStB_MEMU_Rd, bus.LdStB_MEMU_opcode,
                     bus.LdStB_MEMU_Address, bus.LdStB_MEMU_WriteData);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_load_basic();
        alloc_in(LW, 5'd3, 5'd9, 5'd0, 5'd0, 32'd100, 32'd0, 32'd8);
        tick();
        vectors++;
        if (bus.LdStB_MEMU_VALID !== 1'b0 || bus.LdStB_EMPTY !== 1'b0) begin
            miscompares++;
            $display("FAIL load_alloc: valid=%b empty=%b, required 0/0",
                     bus.LdStB_MEMU_VALID, bus.LdStB_EMPTY);
        end
        tick();
        vectors++;
        if (bus.LdStB_MEMU_VALID !== 1'b1 || bus.LdStB_MEMU_Address !== 11'd108 ||
            bus.LdStB_MEMU_ROBEN !== 5'd3 || bus.LdStB_MEMU_WriteData !== 32'd0 ||
            bus.LdStB_MEMU_opcode !== LW || bus.LdStB_MEMU_Rd !== 5'd9 || bus.LdStB_EMPTY !== 1'b1) begin
            miscompares++;
            $display("FAIL load_issue: valid=%b addr=%0d roben=%0d wdata=%h op=%h rd=%0d empty=%b, required 1/108/3/0/8c0/9/1",
                     bus.LdStB_MEMU_VALID, bus.LdStB_MEMU_Address, bus.LdStB_MEMU_ROBEN,
                     bus.LdStB_MEMU_WriteData, bus.LdStB_MEMU_opcode, bus.LdStB_MEMU_Rd,
                     bus.LdStB_EMPTY);
        end
        tick();
        vectors++;
        if (bus.LdStB_MEMU_VALID !== 1'b0 || bus.LdStB_MEMU_Address !== 11'd108) begin
            miscompares++;
            $display("FAIL load_hold: valid=%b addr=%0d, required 0/108",
                     bus.LdStB_MEMU_VALID, bus.LdStB_MEMU_Address);
        end
    endtask

    task automatic test_cdb_wakeup();
        alloc_in(LW, 5'd4, 5'd1, 5'd5, 5'd0, 32'd0, 32'd0, 32'h10);
        tick();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) cdb_in(5'd5, 32'h40);
            tick();
            vectors++;
            if (bus.LdStB_MEMU_VALID !== 1'b0) begin
                miscompares++;
                $display("FAIL wakeup_early cycle %0d: valid=%b, required 0", i, bus.LdStB_MEMU_VALID);
            end
        end
        tick();
        vectors++;
        if (bus.LdStB_MEMU_VALID !== 1'b1 || bus.LdStB_MEMU_Address !== 11'h50 ||
            bus.LdStB_MEMU_ROBEN !== 5'd4) begin
            miscompares++;
            $display("FAIL wakeup_issue: valid=%b addr=%h roben=%0d, required 1/050/4",
                     bus.LdStB_MEMU_VALID, bus.LdStB_MEMU_Address, bus.LdStB_MEMU_ROBEN);
        end
    endtask

    task automatic test_store_commit();
        alloc_in(SW, 5'd7, 5'd0, 5'd0, 5'd0, 32'h200, 32'hDEAD, 32'd4);
        tick();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin bus.ROB_Commit_VALID = 1'b1; bus.ROB_Commit_ROBEN = 5'd6; end
            tick();
            vectors++;
            if (bus.LdStB_MEMU_VALID !== 1'b0) begin
                miscompares++;
                $display("FAIL store_wait cycle %0d: valid=%b, required 0", i, bus.LdStB_MEMU_VALID);
            end
        end
        bus.ROB_Commit_VALID = 1'b1;
        bus.ROB_Commit_ROBEN = 5'd7;
        tick();
        vectors++;
        if (bus.LdStB_MEMU_VALID !== 1'b1 || bus.LdStB_MEMU_opcode !== SW ||
            bus.LdStB_MEMU_WriteData !== 32'hDEAD || bus.LdStB_MEMU_Address !== 11'h204) begin
            miscompares++;
            $display("FAIL store_issue: valid=%b op=%h wdata=%h addr=%h, required 1/ac0/dead/204",
                     bus.LdStB_MEMU_VALID, bus.LdStB_MEMU_opcode, bus.LdStB_MEMU_WriteData,
                     bus.LdStB_MEMU_Address);
        end
    endtask

    task automatic test_full_wrap();
        logic [4:0] want;
        for (int i = 0; i < 16; i++) begin
            alloc_in(LW, 5'(i + 1), 5'(i), (i == 0) ? 5'd20 : 5'd21, 5'd0, 32'd0, 32'd0, 32'(i * 4));
            tick();
        end
        vectors++;
        if (bus.LdStB_FULL !== 1'b1 || bus.LdStB_MEMU_VALID !== 1'b0) begin
            miscompares++;
            $display("FAIL full_flag: full=%b valid=%b, required 1/0", bus.LdStB_FULL, bus.LdStB_MEMU_VALID);
        end
        alloc_in(LW, 5'd31, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        tick();
        cdb_in(5'd20, 32'h100);
        tick();
        vectors++;
        if (bus.LdStB_FULL !== 1'b1 || bus.LdStB_MEMU_VALID !== 1'b0) begin
            miscompares++;
            $display("FAIL full_drop: full=%b valid=%b, required 1/0", bus.LdStB_FULL, bus.LdStB_MEMU_VALID);
        end
        tick();
        vectors++;
        if (bus.LdStB_MEMU_VALID !== 1'b1 || bus.LdStB_MEMU_ROBEN !== 5'd1 ||
            bus.LdStB_MEMU_Address !== 11'h100 || bus.LdStB_FULL !== 1'b0) begin
            miscompares++;
            $display("FAIL full_head_issue: valid=%b roben=%0d addr=%h full=%b, required 1/1/100/0",
                     bus.LdStB_MEMU_VALID, bus.LdStB_MEMU_ROBEN, bus.LdStB_MEMU_Address, bus.LdStB_FULL);
        end
        alloc_in(LW, 5'd30, 5'd2, 5'd0, 5'd0, 32'h300, 32'd0, 32'd0);
        cdb_in(5'd21, 32'h200);
        tick();
        vectors++;
        if (bus.LdStB_MEMU_VALID !== 1'b0 || bus.LdStB_FULL !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_alloc: valid=%b full=%b, required 0/1", bus.LdStB_MEMU_VALID, bus.LdStB_FULL);
        end
        for (int i = 0; i < 16; i++) begin
            want = (i < 15) ? 5'(i + 2) : 5'd30;
            tick();
            vectors++;
            if (bus.LdStB_MEMU_VALID !== 1'b1 || bus.LdStB_MEMU_ROBEN !== want) begin
                miscompares++;
                $display("FAIL wrap_order %0d: valid=%b roben=%0d, required 1/%0d",
                         i, bus.LdStB_MEMU_VALID, bus.LdStB_MEMU_ROBEN, want);
            end
        end
        vectors++;
        if (bus.LdStB_EMPTY !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_empty: empty=%b, required 1", bus.LdStB_EMPTY);
        end
    endtask

    task automatic test_alloc_forward();
        alloc_in(LW, 5'd10, 5'd3, 5'd12, 5'd0, 32'h999, 32'd0, 32'd0);
        cdb_in(5'd12, 32'h123);
        tick();
        vectors++;
        if (bus.LdStB_MEMU_VALID !== 1'b0) begin
            miscompares++;
            $display("FAIL fwd_alloc: valid=%b, required 0", bus.LdStB_MEMU_VALID);
        end
        tick();
        vectors++;
        if (bus.LdStB_MEMU_VALID !== 1'b1 || bus.LdStB_MEMU_Address !== 11'h123 ||
            bus.LdStB_MEMU_ROBEN !== 5'd10) begin
            miscompares++;
            $display("FAIL fwd_issue: valid=%b addr=%h roben=%0d, required 1/123/10",
                     bus.LdStB_MEMU_VALID, bus.LdStB_MEMU_Address, bus.LdStB_MEMU_ROBEN);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            alloc_in(LW, 5'(i + 1), 5'd0, (i == 0) ? 5'd15 : 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
            tick();
        end
        cdb_in(5'd15, 32'h44);
        tick();
        bus.ROB_FLUSH = 1'b1;
        alloc_in(LW, 5'd9, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        tick();
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (bus.LdStB_MEMU_VALID !== 1'b0 || bus.LdStB_EMPTY !== 1'b1) begin
                miscompares++;
                $display("FAIL flush cycle %0d: valid=%b empty=%b, required 0/1",
                         i, bus.LdStB_MEMU_VALID, bus.LdStB_EMPTY);
            end
            tick();
        end
        alloc_in(LW, 5'd6, 5'd0, 5'd0, 5'd0, 32'h10, 32'd0, 32'd0);
        tick();
        tick();
        vectors++;
        if (bus.LdStB_MEMU_VALID !== 1'b1 || bus.LdStB_MEMU_ROBEN !== 5'd6 ||
            bus.LdStB_MEMU_Address !== 11'h10 || bus.LdStB_EMPTY !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_restart: valid=%b roben=%0d addr=%h empty=%b, required 1/6/010/1",
                     bus.LdStB_MEMU_VALID, bus.LdStB_MEMU_ROBEN, bus.LdStB_MEMU_Address,
                     bus.LdStB_EMPTY);
        end
    endtask

    task automatic test_random();
        int r;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(99) < 70) begin
                r = $urandom_range(99);
                alloc_in((r < 45) ? LW : (r < 92) ? SW : 12'($urandom),
                         5'($urandom_range(1, 31)), 5'($urandom),
                         ($urandom_range(1) == 0) ? 5'd0 : 5'($urandom_range(1, 7)),
                         ($urandom_range(1) == 0) ? 5'd0 : 5'($urandom_range(1, 7)),
                         $urandom, $urandom, $urandom);
            end
            if ($urandom_range(1) == 1) cdb_in(5'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(1) == 1) begin
                bus.ROB_Commit_VALID = 1'b1;
                bus.ROB_Commit_ROBEN = (mq.size() > 0 && $urandom_range(3) != 0) ?
                                       mq[0].roben : 5'($urandom);
            end
            if ($urandom_range(99) < 2) bus.ROB_FLUSH = 1'b1;
            tick();
            vectors++;
            if (bus.LdStB_MEMU_VALID !== e_valid || bus.LdStB_FULL !== (mq.size() == 16) ||
                bus.LdStB_EMPTY !== (mq.size() == 0) || bus.LdStB_MEMU_ROBEN !== e_roben ||
                bus.LdStB_MEMU_Rd !== e_rd || bus.LdStB_MEMU_opcode !== e_op ||
                bus.LdStB_MEMU_Address !== e_addr || bus.LdStB_MEMU_WriteData !== e_wdata) begin
                miscompares++;
                $display("FAIL random cycle %0d: got v=%b f=%b e=%b tag=%0d rd=%0d op=%h a=%h d=%h; want v=%b f=%b e=%b tag=%0d rd=%0d op=%h a=%h d=%h",
                         c, bus.LdStB_MEMU_VALID, bus.LdStB_FULL, bus.LdStB_EMPTY,
                         bus.LdStB_MEMU_ROBEN, bus.LdStB_MEMU_Rd, bus.LdStB_MEMU_opcode,
                         bus.LdStB_MEMU_Address, bus.LdStB_MEMU_WriteData, e_valid,
                         mq.size() == 16, mq.size() == 0, e_roben, e_rd, e_op, e_addr, e_wdata);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_cdb_wakeup();
        test_store_commit();
        test_full_wrap();
        test_alloc_forward();
        test_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
